// File: rtl/if_fetch_queue.sv
// Instruction-fetch stage: sequential IM issue with a DEPTH-entry
// decoupling FIFO toward decode, branch redirect/flush and freeze.
module if_fetch_queue #(
    parameter int XLEN    = 32,
    parameter int DEPTH   = 4,
    parameter int PC_STEP = 4
) (
    input  logic                       CLK,
    input  logic                       RESET,
    input  logic [XLEN-1:0]            PC_init,
    input  logic                       FREEZE,
    input  logic                       no_new_fetch,
    input  logic                       taken_branch1,
    input  logic [XLEN-1:0]            nextInstruction_address,
    input  logic                       fetchNull2,
    input  logic [XLEN-1:0]            Instr1_fIM,
    output logic [XLEN-1:0]            Instr_address_2IM,
    output logic                       fetch_req,
    input  logic                       decode_ready,
    output logic                       instr_valid,
    output logic [XLEN-1:0]            Instr_PR,
    output logic [XLEN-1:0]            PCA_PR,
    output logic [$clog2(DEPTH+1)-1:0] fill_count
);

    localparam int CW = $clog2(DEPTH + 1);
    localparam int PW = $clog2(DEPTH);

    logic [XLEN-1:0] pc_q, pc_d;
    logic [XLEN-1:0] fpc_q, fpc_d;
    logic            inflight_q, inflight_d;
    logic [PW-1:0]   rd_q, rd_d;
    logic [PW-1:0]   wr_q, wr_d;
    logic [CW-1:0]   cnt_q, cnt_d;
    logic [XLEN-1:0] instr_mem_q [DEPTH];
    logic [XLEN-1:0] addr_mem_q  [DEPTH];

    logic            redirect;
    logic            push;
    logic            pop;
    logic [CW:0]     occ;

    assign redirect = taken_branch1 && !FREEZE;

    // Slots already promised: queued words plus the one still in the IM.
    assign occ = {1'b0, cnt_q} + {{CW{1'b0}}, inflight_q};

    assign Instr_address_2IM = redirect ? nextInstruction_address : pc_q;

    assign fetch_req = !FREEZE &&
                       (taken_branch1 ||
                        (!no_new_fetch && occ < (CW+1)'(DEPTH)));

    // A return still lands under FREEZE; its slot was reserved at issue.
    assign push = inflight_q && !redirect;

    assign pop = (cnt_q != '0) && decode_ready &&
                 !FREEZE && !taken_branch1;

    assign instr_valid = (cnt_q != '0);
    assign Instr_PR    = instr_mem_q[rd_q];
    assign PCA_PR      = addr_mem_q[rd_q];
    assign fill_count  = cnt_q;

    // Next-state for PC, in-flight tracking and queue bookkeeping.
    always_comb begin
        pc_d       = pc_q;
        fpc_d      = fpc_q;
        inflight_d = fetch_req;
        rd_d       = rd_q;
        wr_d       = wr_q;
        cnt_d      = cnt_q;
        if (fetch_req) begin
            fpc_d = Instr_address_2IM;
            pc_d  = Instr_address_2IM + XLEN'(PC_STEP);
        end
        if (redirect) begin
            rd_d  = '0;
            wr_d  = '0;
            cnt_d = '0;
        end else begin
            wr_d  = wr_q + PW'(push);
            rd_d  = rd_q + PW'(pop);
            cnt_d = cnt_q + CW'(push) - CW'(pop);
        end
    end

    // Control state registers.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            pc_q       <= PC_init;
            fpc_q      <= '0;
            inflight_q <= 1'b0;
            rd_q       <= '0;
            wr_q       <= '0;
            cnt_q      <= '0;
        end else begin
            pc_q       <= pc_d;
            fpc_q      <= fpc_d;
            inflight_q <= inflight_d;
            rd_q       <= rd_d;
            wr_q       <= wr_d;
            cnt_q      <= cnt_d;
        end
    end

    // FIFO storage: returning word (or NOP) paired with its address.
    always_ff @(posedge CLK or negedge RESET) begin
        if (!RESET) begin
            for (int i = 0; i < DEPTH; i++) begin
                instr_mem_q[i] <= '0;
                addr_mem_q[i]  <= '0;
            end
        end else if (push) begin
            instr_mem_q[wr_q] <= fetchNull2 ? '0 : Instr1_fIM;
            addr_mem_q[wr_q]  <= fpc_q;
        end
    end

endmodule

// File: tb/tb_if_fetch_queue.sv
// Directed bench for if_fetch_queue with a one-cycle-latency IM model
// returning addr ^ 0xA5A50000.
module tb_if_fetch_queue;

    logic        CLK = 1'b0;
    logic        RESET = 1'b0;
    logic [31:0] PC_init = 32'h100;
    logic        FREEZE = 1'b0;
    logic        no_new_fetch = 1'b0;
    logic        taken_branch1 = 1'b0;
    logic [31:0] nextInstruction_address = 32'h0;
    logic        fetchNull2 = 1'b0;
    logic [31:0] Instr1_fIM;
    logic [31:0] Instr_address_2IM;
    logic        fetch_req;
    logic        decode_ready = 1'b1;
    logic        instr_valid;
    logic [31:0] Instr_PR;
    logic [31:0] PCA_PR;
    logic [2:0]  fill_count;
    logic [31:0] im_q = 32'h0;

    int checks = 0;
    int errors = 0;

    if_fetch_queue #(.XLEN(32), .DEPTH(4), .PC_STEP(4)) dut (
        .CLK                     (CLK),
        .RESET                   (RESET),
        .PC_init                 (PC_init),
        .FREEZE                  (FREEZE),
        .no_new_fetch            (no_new_fetch),
        .taken_branch1           (taken_branch1),
        .nextInstruction_address (nextInstruction_address),
        .fetchNull2              (fetchNull2),
        .Instr1_fIM              (Instr1_fIM),
        .Instr_address_2IM       (Instr_address_2IM),
        .fetch_req               (fetch_req),
        .decode_ready            (decode_ready),
        .instr_valid             (instr_valid),
        .Instr_PR                (Instr_PR),
        .PCA_PR                  (PCA_PR),
        .fill_count              (fill_count)
    );

    always #5 CLK = ~CLK;

    always @(posedge CLK) im_q <= Instr_address_2IM ^ 32'hA5A50000;
    assign Instr1_fIM = im_q;

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s: observed %h expected %h", tag, obs, exp);
        end
    endtask

    task automatic cyc();
        @(negedge CLK);
        #1;
    endtask

    task automatic do_reset();
        @(negedge CLK);
        RESET = 1'b0;
        #1;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
    endtask

    initial begin
        // reset state
        PC_init = 32'h100;
        decode_ready = 1'b1;
        @(negedge CLK);
        #1;
        chk("rst_valid", 32'(instr_valid), 32'd0);
        chk("rst_fill", 32'(fill_count), 32'd0);
        chk("rst_instr", Instr_PR, 32'h0);
        chk("rst_pca", PCA_PR, 32'h0);
        chk("rst_addr", Instr_address_2IM, 32'h100);
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        // streaming, decode always ready
        chk("s_c0_req", 32'(fetch_req), 32'd1);
        chk("s_c0_addr", Instr_address_2IM, 32'h100);
        cyc();
        chk("s_c1_valid", 32'(instr_valid), 32'd0);
        chk("s_c1_addr", Instr_address_2IM, 32'h104);
        for (int k = 0; k < 5; k++) begin
            cyc();
            chk("s_valid", 32'(instr_valid), 32'd1);
            chk("s_pca", PCA_PR, 32'h100 + 32'(4 * k));
            chk("s_instr", Instr_PR, (32'h100 + 32'(4 * k)) ^ 32'hA5A50000);
        end

        // fill to DEPTH with decode stalled, then drain
        decode_ready = 1'b0;
        do_reset();
        repeat (10) cyc();
        chk("f_fill", 32'(fill_count), 32'd4);
        chk("f_req", 32'(fetch_req), 32'd0);
        chk("f_addr", Instr_address_2IM, 32'h110);
        decode_ready = 1'b1;
        for (int k = 0; k < 8; k++) begin
            chk("d_pca", PCA_PR, 32'h100 + 32'(4 * k));
            chk("d_instr", Instr_PR, (32'h100 + 32'(4 * k)) ^ 32'hA5A50000);
            if (k == 1) chk("d_resume_req", 32'(fetch_req), 32'd1);
            cyc();
        end

        // redirect with count 3 plus an in-flight word
        decode_ready = 1'b0;
        do_reset();
        repeat (4) cyc();
        chk("b_fill_pre", 32'(fill_count), 32'd3);
        taken_branch1 = 1'b1;
        nextInstruction_address = 32'h400;
        #1;
        chk("b_addr", Instr_address_2IM, 32'h400);
        chk("b_req", 32'(fetch_req), 32'd1);
        cyc();
        taken_branch1 = 1'b0;
        chk("b_fill0", 32'(fill_count), 32'd0);
        chk("b_valid0", 32'(instr_valid), 32'd0);
        cyc();
        chk("b_valid", 32'(instr_valid), 32'd1);
        chk("b_pca", PCA_PR, 32'h400);
        chk("b_instr", Instr_PR, 32'hA5A50400);
        decode_ready = 1'b1;
        cyc();
        chk("b_pca1", PCA_PR, 32'h404);
        cyc();
        chk("b_pca2", PCA_PR, 32'h408);

        // FREEZE for 3 cycles with a word in flight
        decode_ready = 1'b1;
        do_reset();
        repeat (2) cyc();
        chk("z_pca_pre", PCA_PR, 32'h100);
        FREEZE = 1'b1;
        taken_branch1 = 1'b1;
        nextInstruction_address = 32'h800;
        #1;
        chk("z_req", 32'(fetch_req), 32'd0);
        chk("z_addr", Instr_address_2IM, 32'h108);
        cyc();
        chk("z_fill1", 32'(fill_count), 32'd2);
        chk("z_pca1", PCA_PR, 32'h100);
        cyc();
        chk("z_fill2", 32'(fill_count), 32'd2);
        chk("z_pca2", PCA_PR, 32'h100);
        chk("z_req2", 32'(fetch_req), 32'd0);
        cyc();
        FREEZE = 1'b0;
        taken_branch1 = 1'b0;
        #1;
        chk("z_res_req", 32'(fetch_req), 32'd1);
        chk("z_res_addr", Instr_address_2IM, 32'h108);
        cyc();
        chk("z_pca3", PCA_PR, 32'h104);
        cyc();
        chk("z_pca4", PCA_PR, 32'h108);
        chk("z_fill4", 32'(fill_count), 32'd1);

        // NOP substitution on the return of 0x108
        decode_ready = 1'b1;
        do_reset();
        repeat (3) cyc();
        chk("n_pca_prev", PCA_PR, 32'h104);
        chk("n_instr_prev", Instr_PR, 32'hA5A50104);
        fetchNull2 = 1'b1;
        cyc();
        fetchNull2 = 1'b0;
        chk("n_pca", PCA_PR, 32'h108);
        chk("n_instr_nop", Instr_PR, 32'h0);
        cyc();
        chk("n_pca_next", PCA_PR, 32'h10C);
        chk("n_instr_next", Instr_PR, 32'hA5A5010C);

        // asynchronous reset mid-stream, restart at new PC_init
        decode_ready = 1'b0;
        do_reset();
        repeat (3) cyc();
        chk("r_fill_pre", 32'(fill_count), 32'd2);
        RESET = 1'b0;
        #1;
        chk("r_valid", 32'(instr_valid), 32'd0);
        chk("r_fill", 32'(fill_count), 32'd0);
        chk("r_pca", PCA_PR, 32'h0);
        PC_init = 32'h200;
        decode_ready = 1'b1;
        @(negedge CLK);
        RESET = 1'b1;
        #1;
        chk("r_addr", Instr_address_2IM, 32'h200);
        chk("r_req", 32'(fetch_req), 32'd1);
        cyc();
        chk("r_valid1", 32'(instr_valid), 32'd0);
        cyc();
        chk("r_pca2", PCA_PR, 32'h200);
        chk("r_instr2", Instr_PR, 32'hA5A50200);

        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end

endmodule

// File: doc/if_fetch_queue.md
# if_fetch_queue

Parametrised instruction-fetch stage with a decoupling queue. It issues one sequential fetch per cycle to the synchronous instruction memory (IM), which has one-cycle read latency. Returned words are buffered with their addresses in a DEPTH-entry FIFO, and decode drains the FIFO through a valid/ready handshake. The block sits between the PC/branch logic and the ID stage, and supports branch redirect with queue flush, global FREEZE, external fetch hold and NOP substitution.

## Interface
- XLEN, 32, instruction and address width
- DEPTH, 4, FIFO entries; power of two, >= 2
- PC_STEP, 4, byte increment between sequential fetches
- CLK  in  1  clock, rising edge
- RESET  in  1  asynchronous, active-low reset
- PC_init  in  XLEN  PC loaded at reset
- FREEZE  in  1  global stall; no issue, pop or redirect
- no_new_fetch  in  1  blocks new IM issue only
- taken_branch1  in  1  redirect request
- nextInstruction_address  in  XLEN  redirect target
- fetchNull2  in  1  word returning this cycle is enqueued as 0 (NOP)
- Instr1_fIM  in  XLEN  IM data for the address issued the previous cycle
- Instr_address_2IM  out  XLEN  IM address; combinational: taken_branch1&&!FREEZE ? nextInstruction_address : PC
- fetch_req  out  1  IM read enable (issue this cycle)
- decode_ready  in  1  ID accepts head entry
- instr_valid  out  1  queue non-empty
- Instr_PR  out  XLEN  head instruction
- PCA_PR  out  XLEN  head instruction address
- fill_count  out  clog2(DEPTH+1)  queue occupancy

## Operation
- State: PC (next sequential address), FPC (address in flight), inflight (1 bit), FIFO storage, rd/wr pointers (clog2(DEPTH) bits, wrap modulo DEPTH), count.
- Issue: fetch_req = !FREEZE && (taken_branch1 || (!no_new_fetch && count + inflight < DEPTH)). On issue: FPC <= Instr_address_2IM; PC <= Instr_address_2IM + PC_STEP, mod 2^XLEN; inflight <= 1. No issue: inflight <= 0, PC and FPC hold.
- Return: if inflight and no redirect this cycle, push {fetchNull2 ? 0 : Instr1_fIM, FPC}. A return is pushed even under FREEZE, because its slot was reserved at issue. Overflow is therefore impossible.
- Pop: when instr_valid && decode_ready && !FREEZE && !taken_branch1, advance rd pointer.
- Push and pop in the same cycle: count unchanged. Pop is not allowed when count = 0, and a push into an empty queue cannot be popped in the same cycle (no bypass).
- Redirect, i.e. taken_branch1 && !FREEZE:
  - count, rd and wr pointers clear to 0.
  - The in-flight word is discarded.
  - The target is issued in the same cycle, regardless of no_new_fetch.
  - Redirect wins over simultaneous pop and return.
- FREEZE: issue, pop and redirect are blocked. PC, FPC and pointers hold, except for the reserved-return push. inflight clears after that push.
- Head outputs (Instr_PR, PCA_PR) are read from registered storage only; there is no combinational path from Instr1_fIM.
- Reset: async clear of all state.
  - PC = PC_init, FPC = 0, inflight = 0, count = 0, pointers = 0, all entries 0.
  - Outputs: instr_valid = 0, Instr_PR = 0, PCA_PR = 0, fill_count = 0.
  - fetch_req = 1 in the first cycle after release (when not frozen), and Instr_address_2IM = PC_init.

## Timing
- Fetch-to-valid latency: address issued in cycle n; data arrives in cycle n+1 and is pushed at the end of n+1; instr_valid is high in cycle n+2.
- Redirect asserted in cycle n: target on Instr_address_2IM in cycle n. instr_valid is 0 in n+1 and goes high with the target at the head in n+2.
- Steady state: one instruction per cycle while decode_ready is held high.
- Full throttle: issue stops while count + inflight = DEPTH and resumes the cycle after a pop.
- RESET asserted mid-operation: state clears immediately, with no wait for the clock edge. Any in-flight data returning after release is ignored because inflight = 0.

## Test plan
- Reset, PC_init=0x100, decode_ready=1, IM returns addr^0xA5A50000 -> fetch_req high from cycle 0; head is (0x100) in cycle 2, then 0x104, 0x108…, one per cycle, with no gaps.
- decode_ready=0 for 10 cycles, DEPTH=4 -> fill_count reaches 4, fetch_req drops to 0, last issued address 0x10C. Raising decode_ready drains the queue in order, with no loss or duplication.
- With queue at count 3 plus an in-flight word, taken_branch1=1 with target 0x400 -> Instr_address_2IM=0x400 in the same cycle; next cycle fill_count=0; the following cycle head PCA_PR=0x400. The pre-branch in-flight word is never output.
- FREEZE for 3 cycles while a fetch is in flight and decode_ready=1 -> that word is enqueued, no pops occur, no new issues occur, and taken_branch1 is ignored. After release, the sequence resumes at the held PC.
- fetchNull2 pulsed on the return of 0x108 -> the entry with PCA_PR=0x108 has Instr_PR=0; neighbouring entries are unaffected.
- RESET pulsed low mid-stream with count=2 -> instr_valid=0 and fill_count=0 immediately. After release, fetching restarts at PC_init.
